// File: rtl/gpio_in_debounce.sv
// Switch/pushbutton input port: two-flop synchroniser, per-bit debouncer,
// rising-edge pending flags with interrupt enables, behind a 16-byte bus window.
module gpio_in_debounce #(
    parameter int          N_SW            = 8,
    parameter int          N_BTN           = 3,
    parameter int          DEBOUNCE_CYCLES = 16000,
    parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SW-1:0]  sw_in,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic [N_BTN-1:0] irq
);

    localparam int unsigned W  = N_SW + N_BTN;
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     stable;
    logic [W-1:0]     stable_d;
    logic [CW-1:0]    cnt [W];
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] enable;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] clr;
    logic             done;
    logic             sel;
    logic             ack;
    logic             wr;
    logic [1:0]       off;
    logic [31:0]      state_view;
    logic [31:0]      raw_view;
    logic [31:0]      rd;
    logic             unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wstrb[3:1], mem_wdata[31:N_BTN]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            sync1    <= {btn_in, sw_in};
            sync2    <= sync1;
            stable_d <= stable;
            // Any sample matching the accepted level restarts that bit's count.
            for (int unsigned i = 0; i < W; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable[W-1:N_SW] & ~stable_d[W-1:N_SW];

    // done blocks a second ack while the same request is still held.
    assign sel = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign ack = sel && !mem_ready && !done;
    assign off = mem_addr[3:2];
    assign wr  = ack && mem_wstrb[0];

    always_comb begin
        state_view = '0;
        raw_view   = '0;
        state_view[N_SW-1:0]  = stable[N_SW-1:0];
        state_view[16+:N_BTN] = stable[W-1:N_SW];
        raw_view[N_SW-1:0]    = sync2[N_SW-1:0];
        raw_view[16+:N_BTN]   = sync2[W-1:N_SW];
    end

    always_comb begin
        rd = '0;
        case (off)
            2'd0: rd = state_view;
            2'd1: rd[N_BTN-1:0] = pending;
            2'd2: rd[N_BTN-1:0] = enable;
            default: rd = raw_view;
        endcase
    end

    always_comb begin
        clr = '0;
        if (wr && off == 2'd1) clr = mem_wdata[N_BTN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            done      <= 1'b0;
            pending   <= '0;
            enable    <= '0;
            irq       <= '0;
        end else begin
            mem_ready <= ack;
            mem_rdata <= ack ? rd : '0;
            done      <= sel && (done || ack);
            pending   <= (pending & ~clr) | rise;
            irq       <= pending & enable;
            if (wr && off == 2'd2) enable <= mem_wdata[N_BTN-1:0];
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed table and sequences plus random traffic
// compared every cycle against a run-length reference model.
module tb_gpio_in_debounce;

    localparam int          N_SW  = 8;
    localparam int          N_BTN = 3;
    localparam int          D     = 4;
    localparam int          W     = N_SW + N_BTN;
    localparam logic [31:0] BASE  = 32'h0300_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_SW-1:0]  sw_in = '0;
    logic [N_BTN-1:0] btn_in = '0;
    logic             mem_valid = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_wstrb = '0;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic [N_BTN-1:0] irq;

    gpio_in_debounce #(.N_SW(N_SW), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(D), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .btn_in(btn_in),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a bit is accepted once the synchronised value has
    // differed from the accepted level for D consecutive edges.
    logic [W-1:0]     m_s1, m_s2, m_stable;
    int               run [W];
    logic [N_BTN-1:0] m_rise, m_pend, m_en, m_irq;
    logic             m_ready, m_done;
    logic [31:0]      m_rdata;

    function automatic logic [31:0] view(input logic [W-1:0] v);
        view = '0;
        view[N_SW-1:0]  = v[N_SW-1:0];
        view[16+:N_BTN] = v[W-1:N_SW];
    endfunction

    task automatic model_step();
        logic [W-1:0]     old_st;
        logic             sel, ack;
        logic [1:0]       off;
        logic [31:0]      rd;
        logic [N_BTN-1:0] clr;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_pend = '0;
            m_en = '0; m_irq = '0; m_ready = 0; m_done = 0; m_rdata = '0;
            for (int b = 0; b < W; b++) run[b] = 0;
        end else begin
            sel = mem_valid && (mem_addr[31:4] == BASE[31:4]);
            ack = sel && !m_ready && !m_done;
            off = mem_addr[3:2];
            case (off)
                2'd0: rd = view(m_stable);
                2'd1: rd = 32'(m_pend);
                2'd2: rd = 32'(m_en);
                default: rd = view(m_s2);
            endcase
            clr = '0;
            if (ack && mem_wstrb[0] && off == 2'd1) clr = mem_wdata[N_BTN-1:0];
            m_irq  = m_pend & m_en;
            m_pend = (m_pend & ~clr) | m_rise;
            if (ack && mem_wstrb[0] && off == 2'd2) m_en = mem_wdata[N_BTN-1:0];
            old_st = m_stable;
            for (int b = 0; b < W; b++) begin
                if (m_s2[b] !== m_stable[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        m_stable[b] = m_s2[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            m_rise  = m_stable[W-1:N_SW] & ~old_st[W-1:N_SW];
            m_done  = sel && (m_done || ack);
            m_ready = ack;
            m_rdata = ack ? rd : 32'h0;
            m_s2 = m_s1;
            m_s1 = {btn_in, sw_in};
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_ready", 32'(mem_ready), 32'(m_ready));
            check("mdl_rdata", mem_rdata, m_rdata);
            check("mdl_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic rdy, output logic [31:0] rdat);
        @(negedge clk);
        mem_addr = a; mem_wstrb = s; mem_wdata = d; mem_valid = 1'b1;
        @(negedge clk);
        rdy = mem_ready; rdat = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic r; logic [31:0] d;
        bus_xfer(a, 4'h0, 32'h0, r, d);
        check({nm, "_ack"}, 32'(r), 32'd1);
        check(nm, d, exp);
    endtask

    task automatic wr_chk(input logic [31:0] a, input logic [31:0] d);
        logic r; logic [31:0] q;
        bus_xfer(a, 4'h1, d, r, q);
        check("wr_ack", 32'(r), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic        r;
        logic [31:0] d;

        vecs[0]  = '{BASE + 32'h8,  4'h1, 32'h5,         1'b1, 32'h5 & 32'h0};
        vecs[1]  = '{BASE + 32'h8,  4'h0, 32'h0,         1'b1, 32'h5};
        vecs[2]  = '{BASE + 32'hA,  4'h0, 32'h0,         1'b1, 32'h5};
        vecs[3]  = '{BASE + 32'h8,  4'h2, 32'hFFFF_FFFF, 1'b1, 32'h5};
        vecs[4]  = '{BASE + 32'h8,  4'h0, 32'h0,         1'b1, 32'h5};
        vecs[5]  = '{BASE + 32'h10, 4'h0, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{BASE + 32'h18, 4'hF, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{BASE + 32'h8,  4'h0, 32'h0,         1'b1, 32'h5};
        vecs[8]  = '{BASE + 32'h0,  4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[9]  = '{BASE + 32'h0,  4'h0, 32'h0,         1'b1, 32'h0};
        vecs[10] = '{BASE + 32'h4,  4'h0, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{BASE + 32'hC,  4'h0, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{BASE + 32'h8,  4'h1, 32'h0,         1'b1, 32'h5};
        vecs[13] = '{BASE + 32'h8,  4'h0, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{32'h0400_0008, 4'h0, 32'h0,         1'b0, 32'h0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        for (int i = 0; i < 15; i++) begin
            bus_xfer(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, r, d);
            check($sformatf("vec%0d_ready", i), 32'(r), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        end

        // Held request: one ack only.
        @(negedge clk);
        mem_addr = BASE; mem_wstrb = '0; mem_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hold_ready_c%0d", c + 2), 32'(mem_ready), (c == 0) ? 32'd1 : 32'd0);
        end
        mem_addr = BASE + 32'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("oow_ready", 32'(mem_ready), 32'd0);
            check("oow_rdata", mem_rdata, 32'd0);
        end
        mem_valid = 1'b0;

        // Switch latency: read presented j edges after the change is sampled.
        for (int j = 1; j <= 7; j++) begin
            for (int reg_sel = 0; reg_sel < 2; reg_sel++) begin
                sw_in = 8'h00;
                repeat (12) @(negedge clk);
                sw_in = 8'hA5;
                repeat (j - 1) @(negedge clk);
                if (reg_sel == 0)
                    rd_chk($sformatf("sw_state_j%0d", j), BASE, (j >= 6) ? 32'hA5 : 32'h0);
                else
                    rd_chk($sformatf("sw_raw_j%0d", j), BASE + 32'hC, (j >= 2) ? 32'hA5 : 32'h0);
            end
        end

        // Glitches of 3 cycles on sw_in[0] never reach STATE.
        repeat (12) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            sw_in[0] = 1'b0;
            rd_chk("glitch_state_low", BASE, 32'hA5);
            @(negedge clk);
            sw_in[0] = 1'b1;
            repeat (3) @(negedge clk);
        end
        rd_chk("glitch_state_end", BASE, 32'hA5);

        // Button interrupt flow.
        wr_chk(BASE + 32'h8, 32'h5);
        btn_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("btn0_pending", BASE + 32'h4, 32'h1);
        check("btn0_irq", 32'(irq), 32'h1);
        wr_chk(BASE + 32'h4, 32'h1);
        check("w1c_irq_at_ack", 32'(irq), 32'h1);
        @(negedge clk);
        check("w1c_irq_after", 32'(irq), 32'h0);
        btn_in[1] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("btn1_pending", BASE + 32'h4, 32'h2);
        check("btn1_irq_masked", 32'(irq), 32'h0);
        rd_chk("btn_state", BASE, 32'h0003_00A5);

        // Clear of bit 2 lands on the same edge that sets it.
        btn_in[2] = 1'b1;
        repeat (5) @(negedge clk);
        bus_xfer(BASE + 32'h4, 4'h1, 32'h4, r, d);
        check("setclr_ack", 32'(r), 32'd1);
        rd_chk("setclr_pending", BASE + 32'h4, 32'h6);
        check("setclr_irq", 32'(irq), 32'h4);
        wr_chk(BASE + 32'h4, 32'h4);
        rd_chk("clr_later_pending", BASE + 32'h4, 32'h2);

        btn_in = '0;
        repeat (12) @(negedge clk);
        wr_chk(BASE + 32'h8, 32'h0);
        wr_chk(BASE + 32'h4, 32'h7);
        rd_chk("clean_pending", BASE + 32'h4, 32'h0);

        // Reset two cycles into a button debounce, with a request outstanding.
        btn_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mem_addr = BASE + 32'h4; mem_wstrb = '0; mem_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", 32'(mem_ready), 32'd0);
        check("midrst_rdata", mem_rdata, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        check("rst_reack_ready", 32'(mem_ready), 32'd1);
        check("rst_reack_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("rst_pend_before", BASE + 32'h4, 32'h0);
        rd_chk("rst_pend_after", BASE + 32'h4, 32'h1);
        check("rst_irq_masked", 32'(irq), 32'd0);
        btn_in = '0;

        // Random traffic against the model.
        begin
            int hold;
            hold = 0;
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                reset = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 5) == 0) sw_in = N_SW'($urandom);
                if ($urandom_range(0, 7) == 0) btn_in = N_BTN'($urandom);
                if (hold > 0) begin
                    hold--;
                end else if (mem_valid) begin
                    mem_valid = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    mem_valid = 1'b1;
                    mem_addr  = BASE + 32'($urandom_range(0, 4) * 4 + $urandom_range(0, 3));
                    mem_wdata = $urandom;
                    case ($urandom_range(0, 3))
                        0: mem_wstrb = 4'h0;
                        1: mem_wstrb = 4'h1;
                        2: mem_wstrb = 4'h2;
                        default: mem_wstrb = 4'hF;
                    endcase
                    hold = $urandom_range(0, 2);
                end
            end
        end
        reset = 1'b0;
        mem_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
